// File: rtl/huff_pkg.sv
// Shared definitions for the Huffman serial encoder/decoder pair.
// Holds the table geometry, the table-entry record and the decoder
// state encoding so that both ends of the link agree on them.
package huff_pkg;

  localparam int SYM_NUM = 8;
  localparam int MAX_LEN = 7;
  localparam int SYM_W   = 3;

  // One code-table entry; len == 0 marks the entry as unused.
  typedef struct packed {
    logic [2:0]         len;
    logic [MAX_LEN-1:0] code;
  } tbl_entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/huff_match.sv
// Combinational codeword matcher.
// Compares a right-aligned candidate codeword of cand_len bits against
// every table entry and reports whether any entry matches, together with
// the lowest matching entry index.
//   entries  : full code table
//   cand     : candidate bits, right-aligned
//   cand_len : number of valid candidate bits (1..MAX_LEN)
//   hit      : some entry matched
//   idx      : lowest matching entry index (0 when no hit)
module huff_match
  import huff_pkg::*;
(
  input  tbl_entry_t [SYM_NUM-1:0] entries,
  input  logic [MAX_LEN-1:0]       cand,
  input  logic [2:0]               cand_len,
  output logic                     hit,
  output logic [SYM_W-1:0]         idx
);

  logic [MAX_LEN-1:0] mask;

  // Only the low cand_len bits take part in the comparison. When cand_len
  // equals MAX_LEN the shift wraps to zero and the subtraction yields all
  // ones, which is exactly the mask wanted.
  assign mask = (MAX_LEN'(1) << cand_len) - MAX_LEN'(1);

  // Scanning from the top down lets lower indices overwrite higher ones,
  // giving lowest-index priority.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = SYM_NUM - 1; i >= 0; i--) begin
      if ((cand_len != 3'd0) && (entries[i].len == cand_len) &&
          (((entries[i].code ^ cand) & mask) == '0)) begin
        hit = 1'b1;
        idx = SYM_W'(i);
      end
    end
  end

endmodule

// File: rtl/huff_serial_decoder.sv
// Serial Huffman decoder.
// Consumes the encoder's one-bit-per-cycle code stream, accumulates bits
// until they form a codeword present in the loaded table, and emits the
// symbol index one cycle later. A frame is a run of consecutive valid
// bits; its end produces a frame_done pulse with final count and error.
//   clk, rst                     : clock, async active-high reset
//   tbl_valid/tbl_sym/len/code   : table write port (honoured in IDLE only)
//   in_valid, in_code            : serial code stream
//   out_valid, out_sym           : decoded symbol pulse and index
//   frame_done                   : end-of-frame pulse
//   sym_cnt                      : symbols in current/last frame, saturating
//   err                          : sticky error of current/last frame
module huff_serial_decoder #(
  parameter int SYM_NUM = huff_pkg::SYM_NUM,
  parameter int MAX_LEN = huff_pkg::MAX_LEN,
  parameter int SYM_W   = huff_pkg::SYM_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tbl_valid,
  input  logic [SYM_W-1:0]   tbl_sym,
  input  logic [2:0]         tbl_len,
  input  logic [MAX_LEN-1:0] tbl_code,
  input  logic               in_valid,
  input  logic               in_code,
  output logic               out_valid,
  output logic [SYM_W-1:0]   out_sym,
  output logic               frame_done,
  output logic [4:0]         sym_cnt,
  output logic               err
);

  import huff_pkg::*;

  tbl_entry_t [SYM_NUM-1:0] entries;

  state_t             state, state_n;
  logic [MAX_LEN-1:0] acc, acc_n;
  logic [2:0]         acc_len, acc_len_n;
  logic [4:0]         cnt_n;
  logic               err_n;
  logic               out_valid_n;
  logic [SYM_W-1:0]   out_sym_n;
  logic               frame_done_n;
  logic               wr_en;
  logic               take_bit;

  logic [MAX_LEN-1:0] base_acc;
  logic [2:0]         base_len;
  logic [4:0]         base_cnt;
  logic               base_err;
  logic [MAX_LEN-1:0] cand;
  logic [2:0]         cand_len;
  logic               hit;
  logic [SYM_W-1:0]   hit_idx;

  // A bit taken in IDLE starts a new frame, so it sees an empty
  // accumulator and fresh count/error rather than the previous frame's.
  always_comb begin
    if (state == IDLE) begin
      base_acc = '0;
      base_len = '0;
      base_cnt = '0;
      base_err = 1'b0;
    end else begin
      base_acc = acc;
      base_len = acc_len;
      base_cnt = sym_cnt;
      base_err = err;
    end
  end

  assign cand     = {base_acc[MAX_LEN-2:0], in_code};
  assign cand_len = base_len + 3'd1;

  huff_match u_match (
    .entries  (entries),
    .cand     (cand),
    .cand_len (cand_len),
    .hit      (hit),
    .idx      (hit_idx)
  );

  // Table storage; writes are only honoured while idle so a running frame
  // always decodes against a stable table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries <= '0;
    end else if (wr_en) begin
      entries[tbl_sym].len  <= tbl_len;
      entries[tbl_sym].code <= tbl_code;
    end
  end

  // Next-state, accumulator, counter and output logic.
  always_comb begin
    state_n      = state;
    acc_n        = acc;
    acc_len_n    = acc_len;
    cnt_n        = sym_cnt;
    err_n        = err;
    out_valid_n  = 1'b0;
    out_sym_n    = '0;
    frame_done_n = 1'b0;
    wr_en        = 1'b0;
    take_bit     = 1'b0;

    case (state)
      IDLE: begin
        wr_en = tbl_valid;
        if (in_valid) begin
          state_n  = DECODE;
          take_bit = 1'b1;
        end
      end
      DECODE: begin
        if (in_valid) begin
          take_bit = 1'b1;
        end else begin
          state_n      = DONE;
          frame_done_n = 1'b1;
          if (acc_len != 3'd0) err_n = 1'b1;
          acc_n     = '0;
          acc_len_n = '0;
        end
      end
      DONE: begin
        state_n = IDLE;
        // A bit arriving while the frame is being closed cannot be decoded.
        if (in_valid) err_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    if (take_bit) begin
      cnt_n = base_cnt;
      err_n = base_err;
      if (hit) begin
        out_valid_n = 1'b1;
        out_sym_n   = hit_idx;
        cnt_n       = (base_cnt == 5'd31) ? base_cnt : base_cnt + 5'd1;
        acc_n       = '0;
        acc_len_n   = '0;
      end else if (cand_len == 3'(MAX_LEN)) begin
        // Longest possible code still unmatched: flag it and resync.
        err_n     = 1'b1;
        acc_n     = '0;
        acc_len_n = '0;
      end else begin
        acc_n     = cand;
        acc_len_n = cand_len;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      acc_len    <= '0;
      sym_cnt    <= '0;
      err        <= 1'b0;
      out_valid  <= 1'b0;
      out_sym    <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      acc_len    <= acc_len_n;
      sym_cnt    <= cnt_n;
      err        <= err_n;
      out_valid  <= out_valid_n;
      out_sym    <= out_sym_n;
      frame_done <= frame_done_n;
    end
  end

endmodule

// File: tb/tb_huff_serial_decoder.sv
// Self-checking bench for huff_serial_decoder. The reference model keeps
// the code table as bit strings and decodes by string comparison.
module tb_huff_serial_decoder;

  import huff_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       tbl_valid;
  logic [2:0] tbl_sym;
  logic [2:0] tbl_len;
  logic [6:0] tbl_code;
  logic       in_valid;
  logic       in_code;
  logic       out_valid;
  logic [2:0] out_sym;
  logic       frame_done;
  logic [4:0] sym_cnt;
  logic       err;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  string m_code[8];
  string m_pend;
  int    m_cnt;
  bit    m_err;
  bit    m_in_frame;

  huff_serial_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .tbl_valid  (tbl_valid),
    .tbl_sym    (tbl_sym),
    .tbl_len    (tbl_len),
    .tbl_code   (tbl_code),
    .in_valid   (in_valid),
    .in_code    (in_code),
    .out_valid  (out_valid),
    .out_sym    (out_sym),
    .frame_done (frame_done),
    .sym_cnt    (sym_cnt),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_code[i] = "";
    m_pend = "";
    m_cnt = 0;
    m_err = 0;
    m_in_frame = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; tbl_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic load_entry(input int sym, input int len, input int code, input bit track);
    string s;
    tbl_valid = 1'b1; tbl_sym = sym[2:0]; tbl_len = len[2:0]; tbl_code = code[6:0];
    @(posedge clk); #1;
    tbl_valid = 1'b0;
    if (track) begin
      s = "";
      for (int i = len - 1; i >= 0; i--) s = {s, code[i] ? "1" : "0"};
      m_code[sym] = s;
    end
  endtask

  // sym k (<7) is k ones followed by a zero; sym7 is seven ones
  task automatic load_unary();
    for (int k = 0; k < 7; k++) load_entry(k, k + 1, (1 << (k + 1)) - 2, 1'b1);
    load_entry(7, 7, 7'h7f, 1'b1);
  endtask

  task automatic drive_bit(input bit b, output bit ev, output int es);
    in_valid = 1'b1; in_code = b;
    @(posedge clk); #1;
    if (!m_in_frame) begin
      m_in_frame = 1; m_pend = ""; m_cnt = 0; m_err = 0;
    end
    m_pend = {m_pend, b ? "1" : "0"};
    ev = 0; es = 0;
    for (int i = 0; i < 8; i++)
      if (!ev && m_code[i] != "" && m_code[i] == m_pend) begin ev = 1; es = i; end
    if (ev) begin
      m_pend = "";
      if (m_cnt < 31) m_cnt++;
    end else if (m_pend.len() == MAX_LEN) begin
      m_err = 1; m_pend = "";
    end
  endtask

  task automatic drive_end();
    in_valid = 1'b0;
    @(posedge clk); #1;
    if (m_pend != "") m_err = 1;
    m_pend = "";
    m_in_frame = 0;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; tbl_valid = 1'b0;
    in_code = 1'b0; tbl_sym = '0; tbl_len = '0; tbl_code = '0;
    #12;
    n_total++;
    if ({out_valid, out_sym, frame_done, sym_cnt, err} !== 11'd0)
      $display("[TB] FAIL reset_outputs actual=%h required=0", {out_valid, out_sym, frame_done, sym_cnt, err});
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_basic();
    bit b_q[$] = '{0, 1, 0, 1, 1, 0};
    bit ev; int es;
    string log_s = "";
    load_unary();
    foreach (b_q[k]) begin
      drive_bit(b_q[k], ev, es);
      n_total++;
      if ({out_valid, out_sym, frame_done, err} !== {ev, es[2:0], 1'b0, m_err})
        $display("[TB] FAIL basic_bit%0d actual=%h required=%h", k, {out_valid, out_sym, frame_done, err}, {ev, es[2:0], 1'b0, m_err});
      else n_pass++;
      if (out_valid) log_s = {log_s, $sformatf("%0d@%0d ", out_sym, k)};
    end
    n_total++;
    if (log_s != "0@0 1@2 2@5 ") $display("[TB] FAIL basic_sequence actual='%s' required='0@0 1@2 2@5 '", log_s);
    else n_pass++;
    drive_end();
    n_total++;
    if ({out_valid, frame_done, sym_cnt, err} !== {1'b0, 1'b1, 5'd3, 1'b0})
      $display("[TB] FAIL basic_end actual=%h required=%h", {out_valid, frame_done, sym_cnt, err}, {1'b0, 1'b1, 5'd3, 1'b0});
    else n_pass++;
    idle_cycle();
    n_total++;
    if (frame_done !== 1'b0) $display("[TB] FAIL basic_fd_pulse actual=%b required=0", frame_done);
    else n_pass++;
  endtask

  task automatic test_zeros();
    bit ev; int es; int highs;
    int lens[2] = '{5, 35};
    int cnts[2] = '{5, 31};
    for (int f = 0; f < 2; f++) begin
      highs = 0;
      for (int k = 0; k < lens[f]; k++) begin
        drive_bit(1'b0, ev, es);
        n_total++;
        if ({out_valid, out_sym, err} !== {ev, es[2:0], m_err})
          $display("[TB] FAIL zeros_bit%0d actual=%h required=%h", k, {out_valid, out_sym, err}, {ev, es[2:0], m_err});
        else n_pass++;
        if (out_valid) highs++;
      end
      n_total++;
      if (highs != lens[f]) $display("[TB] FAIL zeros_run actual=%0d required=%0d", highs, lens[f]);
      else n_pass++;
      drive_end();
      n_total++;
      if ({frame_done, sym_cnt, err} !== {1'b1, 5'(cnts[f]), 1'b0})
        $display("[TB] FAIL zeros_end actual=%h required=%h", {frame_done, sym_cnt, err}, {1'b1, 5'(cnts[f]), 1'b0});
      else n_pass++;
      idle_cycle();
    end
  endtask

  task automatic test_partial();
    bit ev; int es;
    drive_bit(1'b1, ev, es);
    drive_bit(1'b1, ev, es);
    n_total++;
    if (out_valid !== 1'b0) $display("[TB] FAIL partial_nosym actual=%b required=0", out_valid);
    else n_pass++;
    drive_end();
    n_total++;
    if ({frame_done, sym_cnt, err} !== {1'b1, 5'd0, 1'b1})
      $display("[TB] FAIL partial_end actual=%h required=%h", {frame_done, sym_cnt, err}, {1'b1, 5'd0, 1'b1});
    else n_pass++;
    idle_cycle();
  endtask

  task automatic test_overflow();
    bit b_q[$] = '{1, 1, 1, 1, 1, 1, 1, 0, 1};
    bit ev; int es;
    do_reset();
    load_entry(0, 2, 0, 1'b1);
    load_entry(1, 2, 1, 1'b1);
    foreach (b_q[k]) begin
      drive_bit(b_q[k], ev, es);
      n_total++;
      if ({out_valid, out_sym, err} !== {ev, es[2:0], m_err})
        $display("[TB] FAIL overflow_bit%0d actual=%h required=%h", k, {out_valid, out_sym, err}, {ev, es[2:0], m_err});
      else n_pass++;
      if (k == 6) begin
        n_total++;
        if (err !== 1'b1) $display("[TB] FAIL overflow_err actual=%b required=1", err);
        else n_pass++;
      end
    end
    n_total++;
    if ({out_valid, out_sym} !== 4'b1_001) $display("[TB] FAIL overflow_resync actual=%h required=9", {out_valid, out_sym});
    else n_pass++;
    drive_end();
    idle_cycle();
  endtask

  task automatic test_ignored_write();
    bit b_q[$] = '{1, 1, 0};
    bit ev; int es;
    drive_bit(1'b0, ev, es);
    tbl_valid = 1'b1; tbl_sym = 3'd2; tbl_len = 3'd3; tbl_code = 7'd6;
    drive_bit(1'b0, ev, es);
    tbl_valid = 1'b0;
    n_total++;
    if ({out_valid, out_sym} !== {ev, es[2:0]})
      $display("[TB] FAIL ignwr_sym actual=%h required=%h", {out_valid, out_sym}, {ev, es[2:0]});
    else n_pass++;
    drive_end();
    idle_cycle();
    foreach (b_q[k]) begin
      drive_bit(b_q[k], ev, es);
      n_total++;
      if (out_valid !== 1'b0) $display("[TB] FAIL ignwr_bit%0d actual=%b required=0", k, out_valid);
      else n_pass++;
    end
    drive_end();
    n_total++;
    if ({frame_done, sym_cnt, err} !== {1'b1, 5'd0, 1'b1})
      $display("[TB] FAIL ignwr_end actual=%h required=%h", {frame_done, sym_cnt, err}, {1'b1, 5'd0, 1'b1});
    else n_pass++;
    idle_cycle();
  endtask

  task automatic test_done_bit();
    bit ev; int es;
    do_reset();
    load_unary();
    drive_bit(1'b0, ev, es);
    drive_end();
    in_valid = 1'b1; in_code = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    m_err = 1;
    n_total++;
    if ({out_valid, sym_cnt, err} !== {1'b0, 5'(m_cnt), m_err})
      $display("[TB] FAIL done_bit actual=%h required=%h", {out_valid, sym_cnt, err}, {1'b0, 5'(m_cnt), m_err});
    else n_pass++;
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    bit ev; int es;
    drive_bit(1'b0, ev, es);
    n_total++;
    if ({out_valid, sym_cnt} !== {1'b1, 5'd1}) $display("[TB] FAIL rstmid_pre actual=%h required=21", {out_valid, sym_cnt});
    else n_pass++;
    #2; rst = 1'b1; in_valid = 1'b0;
    #1;
    n_total++;
    if ({out_valid, out_sym, frame_done, sym_cnt, err} !== 11'd0)
      $display("[TB] FAIL rstmid_outputs actual=%h required=0", {out_valid, out_sym, frame_done, sym_cnt, err});
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    for (int k = 0; k < 3; k++) begin
      idle_cycle();
      n_total++;
      if (frame_done !== 1'b0) $display("[TB] FAIL rstmid_nofd%0d actual=%b required=0", k, frame_done);
      else n_pass++;
    end
    drive_bit(1'b0, ev, es);
    n_total++;
    if (out_valid !== ev) $display("[TB] FAIL rstmid_empty actual=%b required=%b", out_valid, ev);
    else n_pass++;
    drive_end();
    n_total++;
    if ({frame_done, sym_cnt, err} !== {1'b1, 5'(m_cnt), m_err})
      $display("[TB] FAIL rstmid_end actual=%h required=%h", {frame_done, sym_cnt, err}, {1'b1, 5'(m_cnt), m_err});
    else n_pass++;
    idle_cycle();
  endtask

  task automatic test_roundtrip();
    bit ev; int es;
    int syms[5];
    string want, got;
    load_unary();
    for (int r = 0; r < 2; r++) begin
      want = ""; got = "";
      for (int k = 0; k < 5; k++) begin
        syms[k] = $urandom_range(0, 7);
        want = {want, $sformatf("%0d ", syms[k])};
      end
      for (int k = 0; k < 5; k++)
        for (int j = 0; j < m_code[syms[k]].len(); j++) begin
          drive_bit(m_code[syms[k]][j] == "1", ev, es);
          if (out_valid) got = {got, $sformatf("%0d ", out_sym)};
        end
      drive_end();
      n_total++;
      if (got != want) $display("[TB] FAIL roundtrip%0d actual='%s' required='%s'", r, got, want);
      else n_pass++;
      n_total++;
      if ({frame_done, sym_cnt, err} !== {1'b1, 5'd5, 1'b0})
        $display("[TB] FAIL roundtrip%0d_end actual=%h required=%h", r, {frame_done, sym_cnt, err}, {1'b1, 5'd5, 1'b0});
      else n_pass++;
      idle_cycle();
    end
  endtask

  task automatic test_random();
    bit ev; int es; int n;
    do_reset();
    for (int it = 0; it < 8; it++) begin
      for (int w = 0; w < 4; w++)
        load_entry($urandom_range(0, 7), $urandom_range(0, 7), int'($urandom_range(0, 127)), 1'b1);
      n = $urandom_range(1, 24);
      for (int k = 0; k < n; k++) begin
        drive_bit(1'($urandom_range(0, 1)), ev, es);
        n_total++;
        if ({out_valid, out_sym, frame_done, err} !== {ev, es[2:0], 1'b0, m_err})
          $display("[TB] FAIL random%0d_bit%0d actual=%h required=%h", it, k, {out_valid, out_sym, frame_done, err}, {ev, es[2:0], 1'b0, m_err});
        else n_pass++;
      end
      drive_end();
      n_total++;
      if ({out_valid, frame_done, sym_cnt, err} !== {1'b0, 1'b1, 5'(m_cnt), m_err})
        $display("[TB] FAIL random%0d_end actual=%h required=%h", it, {out_valid, frame_done, sym_cnt, err}, {1'b0, 1'b1, 5'(m_cnt), m_err});
      else n_pass++;
      idle_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zeros();
    test_partial();
    test_overflow();
    test_ignored_write();
    test_done_bit();
    test_reset_mid();
    test_roundtrip();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
